sensor_scheduler: RTL

//  Round-robin sequencer for the three HC-SR04 ultrasonic sensors feeding the position datapath.

---
 rtl/sensor_scheduler_if.sv | 21 ++
 rtl/sensor_scheduler.sv | 114 +++++++++++
 2 files changed

// File: rtl/sensor_scheduler_if.sv
// sensor_scheduler_if: echo/trigger lines and published frame of the ultrasonic sequencer
interface sensor_scheduler_if;
    logic        enable;
    logic [2:0]  echo;
    logic [2:0]  trig;
    logic [11:0] dist_s1;
    logic [11:0] dist_s2;
    logic [11:0] dist_s3;
    logic        frame_valid;
    logic [2:0]  sensor_timeout;
    logic [1:0]  active_sensor;
    logic        busy;
    modport master (
        input  enable, echo,
        output trig, dist_s1, dist_s2, dist_s3, frame_valid, sensor_timeout, active_sensor, busy
    );
    modport slave (
        output enable, echo,
        input  trig, dist_s1, dist_s2, dist_s3, frame_valid, sensor_timeout, active_sensor, busy
    );
endinterface

// File: rtl/sensor_scheduler.sv
// sensor_scheduler: round-robin HC-SR04 trigger/echo sequencer publishing three distances per frame
module sensor_scheduler #(
    parameter int TRIG_CYCLES      = 500,
    parameter int CM_CYCLES        = 2900,
    parameter int ECHO_WAIT_CYCLES = 1_500_000,
    parameter int GUARD_CYCLES     = 3_000_000,
    parameter int MAX_CM           = 400
) (
    input logic                 clk,
    input logic                 reset,
    sensor_scheduler_if.master  bus
);
    localparam int M1   = (TRIG_CYCLES > ECHO_WAIT_CYCLES) ? TRIG_CYCLES : ECHO_WAIT_CYCLES;
    localparam int MAXC = (M1 > GUARD_CYCLES) ? M1 : GUARD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = $clog2(CM_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, GUARD} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pre;
    logic [11:0]   cm;
    logic [2:0]    echo_m, echo_s, echo_d;
    logic [1:0]    active;
    logic [11:0]   sh0, sh1;
    logic [1:0]    to_sh;
    logic          e, rise, done, to_new;
    logic [11:0]   dist_new;
    assign e                 = echo_s[active];
    assign rise              = e & ~echo_d[active];
    assign bus.trig          = (state == TRIG) ? 3'b001 << active : 3'b000;
    assign bus.busy          = state != IDLE;
    assign bus.active_sensor = active;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;
    always_comb begin
        state_n  = state;
        done     = 1'b0;
        to_new   = 1'b0;
        dist_new = cm;
        unique case (state)
            IDLE:      state_n = bus.enable ? TRIG : IDLE;
            TRIG:      state_n = (cnt == CW'(TRIG_CYCLES - 1)) ? WAIT_ECHO : TRIG;
            WAIT_ECHO: begin
                if (rise) state_n = MEASURE;
                else if (cnt == CW'(ECHO_WAIT_CYCLES - 1)) begin
                    state_n  = GUARD;
                    done     = 1'b1;
                    to_new   = 1'b1;
                    dist_new = 12'hFFF;
                end
            end
            MEASURE: begin
                // out of range is reported as invalid distance, not as a timeout
                if (cm > 12'(MAX_CM)) begin
                    state_n  = GUARD;
                    done     = 1'b1;
                    dist_new = 12'hFFF;
                end else if (!e) begin
                    state_n = GUARD;
                    done    = 1'b1;
                end
            end
            GUARD:   state_n = (cnt != CW'(GUARD_CYCLES - 1)) ? GUARD :
                               (active != 2'd2 || bus.enable) ? TRIG : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            {echo_d, echo_s, echo_m} <= '0;
            cnt                <= '0;
            pre                <= '0;
            cm                 <= '0;
            active             <= '0;
            sh0                <= '0;
            sh1                <= '0;
            to_sh              <= '0;
            bus.dist_s1        <= '0;
            bus.dist_s2        <= '0;
            bus.dist_s3        <= '0;
            bus.sensor_timeout <= '0;
            bus.frame_valid    <= 1'b0;
        end else begin
            {echo_d, echo_s, echo_m} <= {echo_s, echo_m, bus.echo};
            cnt             <= (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
            bus.frame_valid <= 1'b0;
            if (state == IDLE) active <= 2'd0;
            else if (state == GUARD && state_n != GUARD) active <= (active == 2'd2) ? 2'd0 : active + 2'd1;
            // the rising-edge cycle is already a high cycle, so it is counted
            if (state == WAIT_ECHO && rise) begin
                pre <= PW'(1);
                cm  <= '0;
            end else if (state == MEASURE && e) begin
                pre <= (pre == PW'(CM_CYCLES - 1)) ? '0 : pre + PW'(1);
                cm  <= (pre == PW'(CM_CYCLES - 1) && cm != 12'hFFF) ? cm + 12'd1 : cm;
            end
            if (done && active == 2'd0) begin
                sh0      <= dist_new;
                to_sh[0] <= to_new;
            end
            if (done && active == 2'd1) begin
                sh1      <= dist_new;
                to_sh[1] <= to_new;
            end
            if (done && active == 2'd2) begin
                bus.dist_s1        <= sh0;
                bus.dist_s2        <= sh1;
                bus.dist_s3        <= dist_new;
                bus.sensor_timeout <= {to_new, to_sh};
                bus.frame_valid    <= 1'b1;
            end
        end
endmodule
